branch_cond_unit: RTL

- Sits directly downstream of the comparator. Latches its 2-bit compare result into a flags register.
- Evaluates conditional-branch requests from decode against those flags.
- On a taken branch, drives a redirect request to fetch through a valid/ready handshake, then asserts a pipeline flush for a fixed number of cycles.
- Stalls decode while a redirect or flush is in progress.

---
 rtl/branch_cond_unit_pkg.sv | 30 +++
 rtl/branch_cond_unit_cond_eval.sv | 34 +++
 rtl/branch_cond_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/branch_cond_unit_pkg.sv
// Shared definitions for branch_cond_unit: compare flags, branch condition codes, FSM states.
package branch_cond_unit_pkg;

  localparam int unsigned CMP_W  = 2;
  localparam int unsigned COND_W = 3;
  localparam int unsigned CNT_W  = 4;

  // Comparator result encodings; 2'b00 is "no valid compare yet"
  localparam logic [CMP_W-1:0] CMP_EQ = 2'b01;
  localparam logic [CMP_W-1:0] CMP_L  = 2'b10;
  localparam logic [CMP_W-1:0] CMP_G  = 2'b11;

  typedef enum logic [COND_W-1:0] {
    BR_NEVER  = 3'd0,
    BR_EQ     = 3'd1,
    BR_NE     = 3'd2,
    BR_LT     = 3'd3,
    BR_GE     = 3'd4,
    BR_GT     = 3'd5,
    BR_LE     = 3'd6,
    BR_ALWAYS = 3'd7
  } br_cond_e;

  typedef enum logic [1:0] {
    BCU_IDLE     = 2'd0,
    BCU_REDIRECT = 2'd1,
    BCU_FLUSH    = 2'd2
  } bcu_state_e;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Combinational evaluation of a branch condition code against the compare flags.
module branch_cond_unit_cond_eval
  import branch_cond_unit_pkg::*;
(
  input  logic [CMP_W-1:0]  flags,
  input  logic [COND_W-1:0] br_cond,
  output logic              taken
);

  logic is_eq;
  logic is_l;
  logic is_g;

  assign is_eq = (flags == CMP_EQ);
  assign is_l  = (flags == CMP_L);
  assign is_g  = (flags == CMP_G);

  // An unrecognised flags value leaves all three terms low, so only ALWAYS is taken
  always_comb begin
    taken = 1'b0;
    case (br_cond_e'(br_cond))
      BR_NEVER:  taken = 1'b0;
      BR_EQ:     taken = is_eq;
      BR_NE:     taken = is_l | is_g;
      BR_LT:     taken = is_l;
      BR_GE:     taken = is_eq | is_g;
      BR_GT:     taken = is_g;
      BR_LE:     taken = is_eq | is_l;
      BR_ALWAYS: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: flags register, taken-branch redirect handshake and timed flush.
// Optional macro CMP_BYPASS_EN lets a same-cycle compare write feed the branch evaluation.
module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CMP_W-1:0]  cmp_in,
  input  logic              cmp_we,
  input  logic              br_valid,
  input  logic [COND_W-1:0] br_cond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  output logic              br_ready,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              redirect_ready,
  output logic              flush,
  output logic              stall,
  output logic [CMP_W-1:0]  flags_out
);

  bcu_state_e       state;
  logic [CMP_W-1:0] flags;
  logic [CNT_W-1:0] cnt;
  logic [CMP_W-1:0] eval_flags;
  logic             taken;

`ifdef CMP_BYPASS_EN
  assign eval_flags = cmp_we ? cmp_in : flags;
  assign br_ready   = (state == BCU_IDLE);
`else
  // A flags write in IDLE holds decode off one cycle so the branch sees the new flags
  assign eval_flags = flags;
  assign br_ready   = (state == BCU_IDLE) && !cmp_we;
`endif

  assign stall     = !br_ready;
  assign flags_out = flags;

  branch_cond_unit_cond_eval u_cond_eval (
    .flags   (eval_flags),
    .br_cond (br_cond),
    .taken   (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= BCU_IDLE;
      flags          <= '0;
      cnt            <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
    end else begin
      if (cmp_we) flags <= cmp_in;
      case (state)
        BCU_IDLE: begin
          if (br_valid && br_ready && taken) begin
            redirect_pc    <= br_pc + br_offset;
            redirect_valid <= 1'b1;
            state          <= BCU_REDIRECT;
          end
        end
        BCU_REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            flush          <= 1'b1;
            cnt            <= CNT_W'(FLUSH_CYCLES);
            state          <= BCU_FLUSH;
          end
        end
        BCU_FLUSH: begin
          // Last flush cycle is the one that sees cnt == 1
          if (cnt <= CNT_W'(1)) begin
            flush <= 1'b0;
            cnt   <= '0;
            state <= BCU_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= BCU_IDLE;
      endcase
    end
  end

endmodule
